// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep fault monitor: FSM encoding,
// syndrome width rule and default persistence threshold.
package lockstep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_SUSPECT = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // Consecutive mismatching samples needed to declare a fault.
    localparam int DEFAULT_PERSIST = 2;

    // Streak counter width; large enough for PERSIST up to 15.
    localparam int STREAK_W = 4;

    // Syndrome carries one extra bit for the carry disagreement.
    function automatic int syn_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stop at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lockstep_fault_monitor.sv
// Lockstep ALU comparator: registers the mismatch syndrome, then decides
// transient vs persistent disagreement, counts samples and mismatches and
// captures the first nonzero syndrome since the last clear.
module lockstep_fault_monitor
    import lockstep_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PERSIST = DEFAULT_PERSIST,
    parameter int CNT_W   = 16
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic                            en_i,
    input  logic                            sample_i,
    input  logic [DATA_W-1:0]               alu_out1_i,
    input  logic [DATA_W-1:0]               alu_out2_i,
    input  logic                            carry1_i,
    input  logic                            carry2_i,
    input  logic [1:0]                      alu_sel_i,
    input  logic                            clr_i,
    output logic                            fault_o,
    output logic                            irq_o,
    output logic [1:0]                      state_o,
    output logic [CNT_W-1:0]                sample_cnt_o,
    output logic [CNT_W-1:0]                mismatch_cnt_o,
    output logic [syn_width(DATA_W)-1:0]    first_syn_o,
    output logic [1:0]                      first_sel_o,
    output logic                            first_vld_o
);

    localparam int SYN_W = syn_width(DATA_W);
    localparam logic [STREAK_W-1:0] PERSIST_L = STREAK_W'(PERSIST);

    logic [SYN_W-1:0]    syn;
    logic [1:0]          sel;
    logic                syn_vld;
    logic                syn_hit;
    logic                eval;
    state_t              state, state_n;
    logic [STREAK_W-1:0] streak, streak_n;
    logic [STREAK_W-1:0] streak_inc;
    logic                irq;

    // Stage 1: register the syndrome and opcode of each enabled sample.
    // Keeps loading during clr_i so a same-cycle sample is not lost.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            syn     <= '0;
            sel     <= '0;
            syn_vld <= 1'b0;
        end else begin
            syn_vld <= sample_i && en_i;
            if (sample_i && en_i) begin
                syn <= {carry1_i ^ carry2_i, alu_out1_i ^ alu_out2_i};
                sel <= alu_sel_i;
            end
        end
    end

    assign syn_hit    = syn_vld && (syn != '0);
    assign eval       = syn_vld && (state != ST_IDLE) && !clr_i;
    assign streak_inc = streak + 1'b1;

    // Stage 2 next-state logic: transient/persistent decision.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        streak_n = streak;
        if (clr_i) begin
            state_n  = en_i ? ST_MONITOR : ST_IDLE;
            streak_n = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (en_i) state_n = ST_MONITOR;
                end
                ST_MONITOR: begin
                    if (!en_i) begin
                        state_n = ST_IDLE;
                    end else if (syn_hit) begin
                        streak_n = streak_inc;
                        state_n  = (streak_inc >= PERSIST_L) ? ST_FAULT : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (!en_i) begin
                        state_n  = ST_IDLE;
                        streak_n = '0;
                    end else if (syn_hit) begin
                        streak_n = streak_inc;
                        if (streak_inc >= PERSIST_L) state_n = ST_FAULT;
                    end else if (syn_vld) begin
                        state_n  = ST_MONITOR;
                        streak_n = '0;
                    end
                end
                ST_FAULT: begin
                    state_n = ST_FAULT;
                end
                default: begin
                    state_n  = ST_IDLE;
                    streak_n = '0;
                end
            endcase
        end
    end

    // Stage 2 state register plus the registered FAULT-entry pulse.
    // NOTE: control state is reset asynchronously so fault_o drops the
    // moment wb_rst_ni falls, without waiting for a clock edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state  <= ST_IDLE;
            streak <= '0;
            irq    <= 1'b0;
        end else begin
            state  <= state_n;
            streak <= streak_n;
            irq    <= (state_n == ST_FAULT) && (state != ST_FAULT);
        end
    end

    // Capture the first nonzero syndrome since the last clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            first_syn_o <= '0;
            first_sel_o <= '0;
            first_vld_o <= 1'b0;
        end else if (clr_i) begin
            first_syn_o <= '0;
            first_sel_o <= '0;
            first_vld_o <= 1'b0;
        end else if (eval && (syn != '0) && !first_vld_o) begin
            first_syn_o <= syn;
            first_sel_o <= sel;
            first_vld_o <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .inc   (eval),
        .clr   (clr_i),
        .count (sample_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mismatch_cnt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .inc   (eval && (syn != '0)),
        .clr   (clr_i),
        .count (mismatch_cnt_o)
    );

    assign fault_o = (state == ST_FAULT);
    assign irq_o   = irq;
    assign state_o = state;

endmodule

// File: tb/tb_lockstep_fault_monitor.sv
// Self-checking bench for lockstep_fault_monitor (PERSIST=2, CNT_W=4):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_lockstep_fault_monitor;

    localparam int DATA_W  = 8;
    localparam int PERSIST = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_ni = 1'b0;
    logic              en_i = 1'b0;
    logic              sample_i = 1'b0;
    logic [DATA_W-1:0] alu_out1_i = '0;
    logic [DATA_W-1:0] alu_out2_i = '0;
    logic              carry1_i = 1'b0;
    logic              carry2_i = 1'b0;
    logic [1:0]        alu_sel_i = '0;
    logic              clr_i = 1'b0;
    logic              fault_o;
    logic              irq_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  sample_cnt_o;
    logic [CNT_W-1:0]  mismatch_cnt_o;
    logic [DATA_W:0]   first_syn_o;
    logic [1:0]        first_sel_o;
    logic              first_vld_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending sample plus observable results.
    int m_pend_vld, m_pend_syn, m_pend_sel;
    int m_mode;      // 0 idle, 1 watching, 2 suspicious, 3 faulted
    int m_run;       // consecutive mismatches seen
    int m_samples, m_mism, m_first_syn, m_first_sel, m_first_vld, m_irq;

    lockstep_fault_monitor #(
        .DATA_W (DATA_W),
        .PERSIST(PERSIST),
        .CNT_W  (CNT_W)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .en_i          (en_i),
        .sample_i      (sample_i),
        .alu_out1_i    (alu_out1_i),
        .alu_out2_i    (alu_out2_i),
        .carry1_i      (carry1_i),
        .carry2_i      (carry2_i),
        .alu_sel_i     (alu_sel_i),
        .clr_i         (clr_i),
        .fault_o       (fault_o),
        .irq_o         (irq_o),
        .state_o       (state_o),
        .sample_cnt_o  (sample_cnt_o),
        .mismatch_cnt_o(mismatch_cnt_o),
        .first_syn_o   (first_syn_o),
        .first_sel_o   (first_sel_o),
        .first_vld_o   (first_vld_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic model_reset();
        m_pend_vld = 0; m_pend_syn = 0; m_pend_sel = 0;
        m_mode = 0; m_run = 0;
        m_samples = 0; m_mism = 0;
        m_first_syn = 0; m_first_sel = 0; m_first_vld = 0; m_irq = 0;
    endtask

    // Apply one cycle of inputs, advance the model, then sample #1 after the edge.
    task automatic step(input bit en, input bit smp, input int a1, input int a2,
                        input bit c1, input bit c2, input int sel, input bit clr);
        int old_mode;
        en_i = en; sample_i = smp; alu_out1_i = a1[7:0]; alu_out2_i = a2[7:0];
        carry1_i = c1; carry2_i = c2; alu_sel_i = sel[1:0]; clr_i = clr;
        old_mode = m_mode;
        if (clr) begin
            m_samples = 0; m_mism = 0; m_first_vld = 0; m_first_syn = 0; m_first_sel = 0;
            m_run = 0;
            m_mode = en ? 1 : 0;
        end else begin
            if (m_mode != 0 && m_pend_vld != 0) begin
                m_samples = (m_samples + 1 > CNT_MAX) ? CNT_MAX : m_samples + 1;
                if (m_pend_syn != 0) begin
                    m_mism = (m_mism + 1 > CNT_MAX) ? CNT_MAX : m_mism + 1;
                    if (m_first_vld == 0) begin
                        m_first_vld = 1; m_first_syn = m_pend_syn; m_first_sel = m_pend_sel;
                    end
                end
            end
            if (m_mode == 3) begin
                m_mode = 3;
            end else if (m_mode == 0) begin
                if (en) m_mode = 1;
            end else if (!en) begin
                m_mode = 0; m_run = 0;
            end else if (m_pend_vld != 0) begin
                if (m_pend_syn != 0) begin
                    m_run++;
                    m_mode = (m_run >= PERSIST) ? 3 : 2;
                end else begin
                    m_run = 0; m_mode = 1;
                end
            end
        end
        m_irq = (m_mode == 3 && old_mode != 3) ? 1 : 0;
        m_pend_vld = (smp && en) ? 1 : 0;
        if (smp && en) begin
            m_pend_syn = ((c1 ^ c2) ? 256 : 0) + ((a1 ^ a2) & 255);
            m_pend_sel = sel & 3;
        end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle_step(input bit en);
        step(en, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        wb_rst_ni = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;
        checks++;
        if ({fault_o, irq_o, state_o, sample_cnt_o, mismatch_cnt_o, first_syn_o,
             first_sel_o, first_vld_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d fault=%0b irq=%0b scnt=%0d mcnt=%0d fsyn=%0h fvld=%0b, all required 0",
                     state_o, fault_o, irq_o, sample_cnt_o, mismatch_cnt_o, first_syn_o, first_vld_o);
        end
        idle_step(1'b1);
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL reset_enable: state=%0d required 1", state_o);
        end
    endtask

    task automatic test_match_stream();
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 'h5A, 'h5A, 1'b1, 1'b1, i, 1'b0);
        idle_step(1'b1);
        checks++;
        if (sample_cnt_o !== 4'd4 || mismatch_cnt_o !== 4'd0 || fault_o !== 1'b0
            || sample_cnt_o !== CNT_W'(m_samples)) begin
            errors++;
            $display("FAIL match_stream: scnt=%0d mcnt=%0d fault=%0b required 4/0/0",
                     sample_cnt_o, mismatch_cnt_o, fault_o);
        end
    endtask

    task automatic test_transient();
        logic saw_irq;
        logic [1:0] st_a;
        saw_irq = 1'b0;
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 'h5A, 'h58, 1'b0, 1'b0, 3, 1'b0);
        saw_irq |= irq_o;
        step(1'b1, 1'b1, 'h5A, 'h5A, 1'b0, 1'b0, 0, 1'b0);
        saw_irq |= irq_o;
        st_a = state_o;
        idle_step(1'b1);
        saw_irq |= irq_o;
        checks++;
        if (st_a !== 2'd2 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL transient_states: got %0d then %0d required 2 then 1", st_a, state_o);
        end
        checks++;
        if (mismatch_cnt_o !== 4'd1 || first_syn_o !== 9'h002 || first_vld_o !== 1'b1
            || first_sel_o !== 2'd3 || saw_irq !== 1'b0) begin
            errors++;
            $display("FAIL transient_capture: mcnt=%0d fsyn=%0h fsel=%0d fvld=%0b irq_seen=%0b required 1/002/3/1/0",
                     mismatch_cnt_o, first_syn_o, first_sel_o, first_vld_o, saw_irq);
        end
    endtask

    task automatic test_persistent();
        logic f_early;
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 'h10, 'h11, 1'b1, 1'b0, 1, 1'b0);
        step(1'b1, 1'b1, 'h10, 'h11, 1'b1, 1'b0, 1, 1'b0);
        f_early = fault_o | irq_o;
        idle_step(1'b1);
        checks++;
        if (f_early !== 1'b0 || fault_o !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL persistent_entry: early=%0b fault=%0b irq=%0b required 0/1/1",
                     f_early, fault_o, irq_o);
        end
        idle_step(1'b1);
        checks++;
        if (irq_o !== 1'b0 || fault_o !== 1'b1) begin
            errors++;
            $display("FAIL persistent_irq_width: irq=%0b fault=%0b required 0/1", irq_o, fault_o);
        end
        checks++;
        if (first_syn_o !== 9'h101 || first_sel_o !== 2'd1 || mismatch_cnt_o !== 4'd2) begin
            errors++;
            $display("FAIL persistent_capture: fsyn=%0h fsel=%0d mcnt=%0d required 101/1/2",
                     first_syn_o, first_sel_o, mismatch_cnt_o);
        end
        idle_step(1'b0);
        idle_step(1'b0);
        checks++;
        if (state_o !== 2'd3 || fault_o !== 1'b1) begin
            errors++;
            $display("FAIL persistent_sticky: state=%0d fault=%0b required 3/1", state_o, fault_o);
        end
    endtask

    task automatic test_clear_collision();
        // In FAULT with a nonzero syndrome pending when clr_i arrives.
        step(1'b1, 1'b1, 'hFF, 'h00, 1'b0, 1'b0, 2, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (state_o !== 2'd1 || sample_cnt_o !== 4'd0 || mismatch_cnt_o !== 4'd0
            || first_vld_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_fault: state=%0d scnt=%0d mcnt=%0d fvld=%0b irq=%0b required 1/0/0/0/0",
                     state_o, sample_cnt_o, mismatch_cnt_o, first_vld_o, irq_o);
        end
        // clr_i on the very edge that would enter FAULT.
        step(1'b1, 1'b1, 'h01, 'h02, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 'h01, 'h02, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (state_o !== 2'd1 || irq_o !== 1'b0 || fault_o !== 1'b0 || mismatch_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL clear_at_entry: state=%0d irq=%0b fault=%0b mcnt=%0d required 1/0/0/0",
                     state_o, irq_o, fault_o, mismatch_cnt_o);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i, i ^ 'h80, 1'b0, 1'b0, 0, 1'b0);
        idle_step(1'b1);
        checks++;
        if (mismatch_cnt_o !== 4'd15 || sample_cnt_o !== 4'd15) begin
            errors++;
            $display("FAIL saturation: mcnt=%0d scnt=%0d required 15/15", mismatch_cnt_o, sample_cnt_o);
        end
        step(1'b1, 1'b1, 1, 2, 1'b0, 1'b0, 0, 1'b0);
        idle_step(1'b1);
        checks++;
        if (mismatch_cnt_o !== 4'd15 || first_syn_o !== 9'h080) begin
            errors++;
            $display("FAIL saturation_hold: mcnt=%0d fsyn=%0h required 15/080", mismatch_cnt_o, first_syn_o);
        end
    endtask

    task automatic test_async_reset();
        checks++;
        if (fault_o !== 1'b1) begin
            errors++;
            $display("FAIL async_precondition: fault=%0b required 1", fault_o);
        end
        #3 wb_rst_ni = 1'b0;
        #1;
        checks++;
        if (fault_o !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: fault=%0b state=%0d required 0/0 before next edge", fault_o, state_o);
        end
        model_reset();
        @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_random();
        int nbad;
        nbad = 0;
        for (int i = 0; i < 400; i++) begin
            bit en, smp, clr, c1, c2;
            int a1, a2;
            en  = ($urandom_range(0, 19) != 0);
            smp = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            a1  = $urandom_range(0, 255);
            a2  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : a1;
            c1  = 1'($urandom);
            c2  = ($urandom_range(0, 4) == 0) ? ~c1 : c1;
            step(en, smp, a1, a2, c1, c2, $urandom_range(0, 3), clr);
            checks++;
            if (state_o !== 2'(m_mode) || fault_o !== (m_mode == 3) || irq_o !== 1'(m_irq)
                || sample_cnt_o !== CNT_W'(m_samples) || mismatch_cnt_o !== CNT_W'(m_mism)
                || first_vld_o !== 1'(m_first_vld) || first_syn_o !== 9'(m_first_syn)
                || first_sel_o !== 2'(m_first_sel)) begin
                errors++;
                nbad++;
                if (nbad <= 5)
                    $display("FAIL random_cycle_%0d: state=%0d fault=%0b irq=%0b scnt=%0d mcnt=%0d fsyn=%0h fsel=%0d fvld=%0b required state=%0d irq=%0d scnt=%0d mcnt=%0d fsyn=%0h fsel=%0d fvld=%0d",
                             i, state_o, fault_o, irq_o, sample_cnt_o, mismatch_cnt_o, first_syn_o,
                             first_sel_o, first_vld_o, m_mode, m_irq, m_samples, m_mism,
                             m_first_syn, m_first_sel, m_first_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match_stream();
        test_transient();
        test_persistent();
        test_clear_collision();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lockstep_fault_monitor.md
Name: lockstep_fault_monitor

Overview:
- Consumer end of the dual-ALU lockstep path: takes both ALU result/carry pairs plus a sample strobe, forms the 9-bit mismatch syndrome, and decides whether a disagreement is transient or a persistent fault.
- Keeps saturating sample and mismatch counters and captures the first syndrome since the last clear.
- Raises a sticky fault flag and a one-cycle interrupt pulse intended for user_irq.
- Sits beside the lockstep ALU pair inside the user project and is clocked from the Wishbone clock.

Parameters:
- DATA_W, 8, ALU result width; syndrome width is DATA_W+1.
- PERSIST, 2, consecutive mismatching samples needed to declare FAULT (legal range 1..15).
- CNT_W, 16, width of the sample and mismatch counters.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  monitor enable.
- sample_i  in  1  current ALU outputs are valid this cycle.
- alu_out1_i  in  DATA_W  ALU 1 result.
- alu_out2_i  in  DATA_W  ALU 2 result.
- carry1_i  in  1  ALU 1 carry.
- carry2_i  in  1  ALU 2 carry.
- alu_sel_i  in  2  shared opcode, captured with the first syndrome.
- clr_i  in  1  synchronous clear of fault, counters and capture.
- fault_o  out  1  high while state==FAULT.
- irq_o  out  1  one-cycle pulse on entry to FAULT.
- state_o  out  2  0 IDLE, 1 MONITOR, 2 SUSPECT, 3 FAULT.
- sample_cnt_o  out  CNT_W  samples evaluated.
- mismatch_cnt_o  out  CNT_W  nonzero syndromes seen.
- first_syn_o  out  DATA_W+1  {carry xor, result xor} of the first mismatch.
- first_sel_o  out  2  opcode of the first mismatch.
- first_vld_o  out  1  first_syn_o/first_sel_o are valid.

Behaviour:
- Reset (wb_rst_ni low, asynchronous): every register and output goes to 0; state is IDLE. Reset asserted mid-FAULT drops fault_o immediately.
- Stage 1 (edge k), taken when sample_i&&en_i:
  - register syn = {carry1_i^carry2_i, alu_out1_i^alu_out2_i} and alu_sel_i;
  - set syn_vld for one cycle.
  - sample_i with en_i=0 is ignored.
- Stage 2 (edge k+1): FSM, counters and capture act on the registered syndrome. Latency from the sample to fault_o/irq_o is 2 edges.
- FSM transitions:
  - IDLE: en_i=1 -> MONITOR.
  - MONITOR: syn_vld with syn!=0 -> FAULT if PERSIST==1, else SUSPECT with streak=1. en_i=0 -> IDLE.
  - SUSPECT: syn_vld with syn!=0 -> streak+1; reaching PERSIST -> FAULT. syn_vld with syn==0 -> MONITOR, streak=0. en_i=0 -> IDLE, streak=0. Cycles with no syn_vld hold state.
  - FAULT: sticky and ignores en_i; only clr_i or reset leaves it.
- Counters, while state!=IDLE:
  - each syn_vld increments sample_cnt;
  - each syn_vld with syn!=0 increments mismatch_cnt;
  - both saturate at all-ones, with no wrap;
  - counting continues in FAULT.
- Capture: on the first syn!=0 while first_vld=0, latch syn and sel and set first_vld. Later mismatches do not overwrite it.
- irq_o: high exactly one cycle, on the edge where the state becomes FAULT.
- clr_i (synchronous, any state):
  - zero counters, streak, capture and fault;
  - next state is MONITOR if en_i else IDLE.
  - A syndrome evaluated in the same cycle is discarded: clr wins with no count and no capture.
  - clr_i in the same cycle as FAULT entry suppresses both irq_o and the FAULT entry.
- The stage-1 register keeps loading during clr_i, so a sample taken in the clr cycle is evaluated normally on the next edge.

Decomposition:
- Package lockstep_pkg holds:
  - state encodings ST_IDLE/ST_MONITOR/ST_SUSPECT/ST_FAULT;
  - the SYN_W = DATA_W+1 rule;
  - the default PERSIST.
- One sub-module, sat_counter: parameterised width, inc, clr, saturating, async active-low reset. It is instantiated twice, for samples and mismatches.

Test Plan:
- Reset: hold wb_rst_ni low, then release -> all outputs 0, state_o=0. Assert en_i -> state_o=1 next edge.
- Match stream: en_i=1, 4 samples with out1=out2=0x5A, carries equal -> sample_cnt_o=4, mismatch_cnt_o=0, fault_o=0.
- Transient: sample 0x5A vs 0x58, then one matching sample (PERSIST=2) -> state 1->2->1, mismatch_cnt_o=1, first_syn_o=0x002, first_vld_o=1, irq_o never high.
- Persistent: two consecutive samples of 0x10 vs 0x11 with carry 1 vs 0, sel=2'b01 -> fault_o and irq_o high 2 edges after the second sample; irq_o width 1; first_syn_o=0x101, first_sel_o=1, mismatch_cnt_o=2. Dropping en_i keeps FAULT.
- Clear collision: in FAULT, clr_i coincident with a registered nonzero syndrome -> next state MONITOR, counters 0, first_vld_o=0, no irq_o.
- Saturation and async reset: with CNT_W=4, 20 mismatches -> mismatch_cnt_o=15 and held. Asserting wb_rst_ni between clock edges while in FAULT -> fault_o=0 immediately, before the next edge.
